im_bus_arbiter: RTL and testbench

- Sequences a single word-wide memory device (ce/we/re/be/din/dout/ready interface, as used by instruction memory) and shares it between two requesters.
- Requester 0 is instruction fetch (read-only). Requester 1 is the data port (read/write, byte enables).
- Arbitration is round-robin. Requests are latched, memory wait states are absorbed, each transaction is completed with a one-cycle done pulse, and a bounded-wait timeout reports an error.

---
 rtl/im_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_im_bus_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/im_bus_arbiter.sv
// Round-robin arbiter that shares one word-wide memory device between
// instruction fetch (m0, read-only) and a data port (m1, read/write).
module im_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic        mem_re,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t      state, state_n;
  logic        last_grant;
  logic        owner;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [CNT_W-1:0] cnt;

  logic elig0, elig1;
  logic winner;
  logic start;
  logic fetch_err;
  logic finish_ok;
  logic finish_to;

  // A requester's stale req during its own done cycle must not re-arbitrate.
  assign elig0 = m0_req & ~m0_done;
  assign elig1 = m1_req & ~m1_done;

  always_comb begin
    state_n   = state;
    winner    = 1'b0;
    start     = 1'b0;
    fetch_err = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          winner = (elig0 && elig1) ? ~last_grant : elig1;
          if (!winner && (m0_addr[1:0] != 2'b00)) begin
            fetch_err = 1'b1;
          end else begin
            start   = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          finish_ok = 1'b1;
          state_n   = IDLE;
        end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
          finish_to = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_be     <= 4'b0000;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      cnt        <= '0;
      m0_done    <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= 32'h0;
      m1_done    <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= 32'h0;
    end else begin
      state    <= state_n;
      m0_done  <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= 32'h0;
      m1_done  <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= 32'h0;

      if (start) begin
        owner      <= winner;
        last_grant <= winner;
        cnt        <= '0;
        if (winner) begin
          lat_we    <= m1_we;
          lat_be    <= m1_be;
          lat_addr  <= m1_addr;
          lat_wdata <= m1_wdata;
        end else begin
          lat_we    <= 1'b0;
          lat_be    <= 4'b1111;
          lat_addr  <= m0_addr;
          lat_wdata <= 32'h0;
        end
      end

      if (fetch_err) begin
        last_grant <= 1'b0;
        m0_done    <= 1'b1;
        m0_err     <= 1'b1;
      end

      if ((state == BUSY) && !mem_ready) begin
        cnt <= cnt + 1'b1;
      end

      // Writes complete with zero read data; aborts report an error with zero data.
      if (finish_ok) begin
        if (owner) begin
          m1_done  <= 1'b1;
          m1_rdata <= lat_we ? 32'h0 : mem_dout;
        end else begin
          m0_done  <= 1'b1;
          m0_rdata <= mem_dout;
        end
      end

      if (finish_to) begin
        if (owner) begin
          m1_done <= 1'b1;
          m1_err  <= 1'b1;
        end else begin
          m0_done <= 1'b1;
          m0_err  <= 1'b1;
        end
      end
    end
  end

  assign busy     = (state == BUSY);
  assign mem_ce   = busy;
  assign mem_we   = busy & lat_we;
  assign mem_re   = busy & ~lat_we;
  assign mem_be   = busy ? lat_be    : 4'b0000;
  assign mem_addr = busy ? lat_addr  : 32'h0;
  assign mem_din  = busy ? lat_wdata : 32'h0;

endmodule

// File: tb/tb_im_bus_arbiter.sv
// Self-checking bench for im_bus_arbiter: vector table plus hand-written
// sequences, completions checked against a scoreboard of expected results.
module tb_im_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_rdata;
  logic        m0_done, m0_err;
  logic        m1_req, m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_done, m1_err;
  logic        mem_ce, mem_we, mem_re;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_ready;
  logic        busy;

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit          port;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_busy;
  } vec_t;

  typedef struct {
    bit          port;
    logic        err;
    logic [31:0] rdata;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[6];

  im_bus_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata),
    .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_re(mem_re), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input bit port, input logic err, input logic [31:0] rdata);
    sb_t e;
    e.port = port;
    e.err = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic checkDone(input bit port, input logic d, input logic e, input logic [31:0] r);
    sb_t exp;
    if (d) begin
      if (sb.size() == 0 || sb[0].port != port) begin
        checks++;
        $display("[TB] FAIL unexpected_done: port %0d got done=1 required no completion", port);
      end else begin
        exp = sb.pop_front();
        checkOutput(port ? "m1_err_rdata" : "m0_err_rdata", {e, r}, {exp.err, exp.rdata});
      end
    end else begin
      checkOutput(port ? "m1_idle_err_rdata" : "m0_idle_err_rdata", {e, r}, 0);
    end
  endtask

  // Scoreboard side: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      checkDone(1'b0, m0_done, m0_err, m0_rdata);
      checkDone(1'b1, m1_done, m1_err, m1_rdata);
    end
  end

  // Drives one transaction and plays the memory, checking bus fields every cycle.
  task automatic applyStimulus(input vec_t v);
    int nbusy = 0;
    int samples = 0;
    bit done_seen = 0;
    logic        e_we  = v.port ? v.we : 1'b0;
    logic [3:0]  e_be  = v.port ? v.be : 4'hF;
    logic [31:0] e_din = v.port ? v.wdata : 32'h0;
    mem_ready = 1'b0;
    mem_dout  = v.dout;
    if (v.port) begin
      m1_we = v.we; m1_be = v.be; m1_addr = v.addr; m1_wdata = v.wdata; m1_req = 1'b1;
    end else begin
      m0_addr = v.addr; m0_req = 1'b1;
    end
    pushExp(v.port, v.exp_err, v.exp_rdata);
    for (int c = 0; c < 40 && !done_seen; c++) begin
      stepCycle();
      samples++;
      if (busy) begin
        nbusy++;
        checkOutput("mem_bus_busy", {mem_ce, mem_we, mem_re, mem_be, mem_addr, mem_din},
                    {1'b1, e_we, ~e_we, e_be, v.addr, e_din});
        mem_ready = (nbusy > v.waits);
      end else begin
        checkOutput("mem_bus_idle", {busy, mem_ce, mem_we, mem_re, mem_be, mem_addr, mem_din}, 0);
      end
      if (v.port ? m1_done : m0_done) begin
        done_seen = 1;
        mem_ready = 1'b0;
        if (v.port) m1_req = 1'b0; else m0_req = 1'b0;
      end
    end
    checkOutput("done_seen", done_seen, 1);
    checkOutput("busy_cycles", nbusy, v.exp_busy);
    checkOutput("done_latency", samples, v.exp_busy + 1);
    stepCycle();
  endtask

  initial begin
    vecs[0] = '{0, 0, 4'h0, 32'h00003000, 32'h0,        32'h24080001, 0,   0, 32'h24080001, 1};
    vecs[1] = '{1, 0, 4'hF, 32'h00000010, 32'h0,        32'hDEADBEEF, 3,   0, 32'hDEADBEEF, 4};
    vecs[2] = '{1, 1, 4'h3, 32'h00000020, 32'h12345678, 32'hAAAA5555, 1,   0, 32'h0,        2};
    vecs[3] = '{1, 0, 4'hF, 32'h00000040, 32'h0,        32'h55555555, 100, 1, 32'h0,        16};
    vecs[4] = '{0, 0, 4'h0, 32'h00003002, 32'h0,        32'h11111111, 0,   1, 32'h0,        0};
    vecs[5] = '{0, 0, 4'h0, 32'h00000004, 32'h0,        32'h0BADF00D, 2,   0, 32'h0BADF00D, 3};

    reset = 1'b1;
    m0_req = 0; m0_addr = 0;
    m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
    mem_dout = 0; mem_ready = 0;
    stepCycle();
    stepCycle();
    checkOutput("reset_outputs",
      {m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata,
       mem_ce, mem_we, mem_re, mem_be, mem_addr, mem_din, busy}, 0);
    reset = 1'b0;
    stepCycle();

    // Simultaneous requests after reset: m1 first, then m0, then a fresh tie goes to m1.
    mem_ready = 1'b1; mem_dout = 32'h24080001;
    m0_addr = 32'h00003000; m0_req = 1'b1;
    m1_we = 1'b1; m1_be = 4'b0001; m1_addr = 32'h10; m1_wdata = 32'hFF; m1_req = 1'b1;
    pushExp(1, 0, 32'h0);
    pushExp(0, 0, 32'h24080001);
    for (int round = 0; round < 2; round++) begin
      stepCycle();
      checkOutput("tie_grant_m1", {busy, mem_we, mem_be, mem_addr, mem_din},
                  {1'b1, 1'b1, 4'b0001, 32'h10, 32'hFF});
      stepCycle();
      checkOutput("tie_m1_done", m1_done, 1);
      m1_req = 1'b0;
      stepCycle();
      checkOutput("tie_then_m0", {busy, mem_we, mem_re, mem_be, mem_addr},
                  {1'b1, 1'b0, 1'b1, 4'hF, 32'h3000});
      stepCycle();
      checkOutput("tie_m0_done", m0_done, 1);
      m0_req = 1'b0;
      stepCycle();
      if (round == 0) begin
        m0_req = 1'b1; m1_req = 1'b1;
        pushExp(1, 0, 32'h0);
        pushExp(0, 0, 32'h24080001);
      end
    end
    mem_ready = 1'b0;
    checkOutput("tie_sb_drained", sb.size(), 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Reset in the middle of a transaction abandons it without a done pulse.
    m1_we = 1'b0; m1_be = 4'hF; m1_addr = 32'h80; m1_req = 1'b1; mem_ready = 1'b0;
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("pre_reset_busy", busy, 1);
    reset = 1'b1;
    m1_req = 1'b0;
    stepCycle();
    checkOutput("mid_reset_outputs",
      {m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata,
       mem_ce, mem_we, mem_re, mem_be, mem_addr, mem_din, busy}, 0);
    reset = 1'b0;
    stepCycle();
    applyStimulus(vecs[1]);
    applyStimulus(vecs[0]);

    stepCycle();
    checkOutput("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
